// File: rtl/gcd_datapath_if.sv
// gcd_datapath_if -- operand/control and result bundle for gcd_datapath.
//   master (controller side): drives data_in, enA, enB, enA_c, enB_c, com_en;
//                             observes eqz, gcd_out, gcd_valid, iter_cnt.
//   slave  (datapath side)  : the reverse.
interface gcd_datapath_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] data_in;
    logic             enA;
    logic             enB;
    logic             enA_c;
    logic             enB_c;
    logic             com_en;
    logic             eqz;
    logic [WIDTH-1:0] gcd_out;
    logic             gcd_valid;
    logic [WIDTH-1:0] iter_cnt;

    modport master (
        output data_in, enA, enB, enA_c, enB_c, com_en,
        input  eqz, gcd_out, gcd_valid, iter_cnt
    );

    modport slave (
        input  data_in, enA, enB, enA_c, enB_c, com_en,
        output eqz, gcd_out, gcd_valid, iter_cnt
    );
endinterface

// File: rtl/gcd_datapath.sv
// gcd_datapath -- subtractive GCD datapath driven by an external controller.
//   clk : single clock, rising edge
//   rst : synchronous active-high reset, clears every register
//   bus : gcd_datapath_if.slave
//         data_in        operand bus, loaded into A/B by enA/enB
//         enA/enB        load A/B (override any conditional update)
//         enA_c/enB_c    permit conditional update of A/B during iterate
//         com_en         iterate/compare enable
//         eqz            A==B, combinational from the registers
//         gcd_out        captured result
//         gcd_valid      gcd_out belongs to the current operand pair
//         iter_cnt       saturating count of updates since the last load
module gcd_datapath #(
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    gcd_datapath_if.slave bus
);
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [WIDTH-1:0] gcd_reg, cnt_reg;
    logic             valid_reg;

    logic             load, iterate, capture;
    logic             a_step, b_step;
    logic [WIDTH-1:0] a_val, b_val;

    assign bus.eqz       = (a_reg == b_reg);
    assign bus.gcd_out   = gcd_reg;
    assign bus.gcd_valid = valid_reg;
    assign bus.iter_cnt  = cnt_reg;

    assign load    = bus.enA | bus.enB;
    assign iterate = bus.com_en & ~load;
    assign capture = iterate & bus.eqz;

    // A zero operand is replaced by the other one instead of subtracting
    // zero forever; the two step conditions are mutually exclusive.
    always_comb begin
        a_step = 1'b0;
        b_step = 1'b0;
        a_val  = a_reg;
        b_val  = b_reg;
        if (iterate && bus.enA_c && b_reg != '0) begin
            if (a_reg == '0) begin
                a_step = 1'b1;
                a_val  = b_reg;
            end else if (a_reg > b_reg) begin
                a_step = 1'b1;
                a_val  = a_reg - b_reg;
            end
        end
        if (iterate && bus.enB_c && a_reg != '0) begin
            if (b_reg == '0) begin
                b_step = 1'b1;
                b_val  = a_reg;
            end else if (b_reg > a_reg) begin
                b_step = 1'b1;
                b_val  = b_reg - a_reg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            gcd_reg   <= '0;
            valid_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            if (bus.enA)
                a_reg <= bus.data_in;
            else if (a_step)
                a_reg <= a_val;

            if (bus.enB)
                b_reg <= bus.data_in;
            else if (b_step)
                b_reg <= b_val;

            if (load) begin
                cnt_reg   <= '0;
                valid_reg <= 1'b0;
            end else begin
                if ((a_step || b_step) && cnt_reg != '1)
                    cnt_reg <= cnt_reg + 1'b1;
                if (capture) begin
                    gcd_reg   <= a_reg;
                    valid_reg <= 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/gcd_datapath.md
GCD_DATAPATH -- requirements
Module: gcd_datapath

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result bit width (>=2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 data_in  input  WIDTH  unsigned operand bus, sampled on load cycles.
REQ-005 enA  input  1  load A register from data_in.
REQ-006 enB  input  1  load B register from data_in.
REQ-007 enA_c  input  1  permit conditional subtract-update of A.
REQ-008 enB_c  input  1  permit conditional subtract-update of B.
REQ-009 com_en  input  1  compare/iterate enable; no conditional update occurs without it.
REQ-010 eqz  output  1  A_reg == B_reg, combinational from registers only.
REQ-011 gcd_out  output  WIDTH  captured result register.
REQ-012 gcd_valid  output  1  gcd_out holds the result of the current operand pair.
REQ-013 iter_cnt  output  WIDTH  subtract iterations performed since the last load, saturating.

Function
REQ-014 State: A_reg, B_reg, gcd_out, gcd_valid and iter_cnt; no other storage.
REQ-015 Load priority: enA=1 -> A_reg<=data_in, overriding any conditional update of A that cycle; enB likewise for B_reg. enA and enB together load both from data_in.
REQ-016 Any load cycle -> iter_cnt<=0 and gcd_valid<=0.
REQ-017 Iterate cycle (com_en=1, no load): if A_reg>B_reg, B_reg!=0 and enA_c=1 -> A_reg<=A_reg-B_reg.
REQ-018 Iterate cycle: if B_reg>A_reg, A_reg!=0 and enB_c=1 -> B_reg<=B_reg-A_reg.
REQ-019 Zero operand, A_reg=0 and B_reg!=0 with enA_c=1: A_reg<=B_reg (one cycle, counts as an iteration). B_reg=0 and A_reg!=0 with enB_c=1: B_reg<=A_reg. No endless subtract of zero.
REQ-020 Both zero: eqz=1 immediately; result 0.
REQ-021 Subtraction is unsigned WIDTH-bit and never underflows (only larger minus smaller); no carry output.
REQ-022 iter_cnt increments by 1 on each cycle in which A_reg or B_reg changes via REQ-017..019; it holds at 2^WIDTH-1.
REQ-023 Capture: com_en=1, eqz=1, no load -> gcd_out<=A_reg, gcd_valid<=1; A_reg/B_reg hold.
REQ-024 com_en=0: A_reg/B_reg change only by load; gcd_out/gcd_valid/iter_cnt hold except per REQ-016.
REQ-025 One subtraction per cycle; eqz reflects the post-edge registers in the same cycle (zero-latency compare), so the controller may exit on the same cycle eqz rises.
REQ-026 enA_c/enB_c asserted without com_en have no effect.

Reset
REQ-027 rst=1 at a clock edge: A_reg=0, B_reg=0, gcd_out=0, gcd_valid=0, iter_cnt=0; rst has priority over every other input.
REQ-028 Consequence: eqz=1 out of reset (0==0); the controller must not sample eqz before operands are loaded.
REQ-029 rst mid-iteration aborts the computation; no partial result is retained.

Verification
REQ-030 Load A=48 then B=18, then com_en=enA_c=enB_c=1 -> (A,B) = (30,18),(12,18),(12,6),(6,6); eqz rises after the 4th iterate edge; gcd_out=6, gcd_valid=1, iter_cnt=4 on the next edge.
REQ-031 A=0, B=25, iterate -> A=25 after 1 edge, eqz=1, gcd_out=25, iter_cnt=1; then A=B=0 -> eqz=1 with no iteration, gcd_out=0.
REQ-032 A=B=7, com_en=1 -> no register change; gcd_out=7 after 1 edge; iter_cnt=0.
REQ-033 enA=1 with data_in=9 in the same cycle as com_en=enA_c=1 and A>B -> A_reg=9, iter_cnt=0, gcd_valid=0.
REQ-034 rst pulsed during the 2nd iterate of 48/18 -> all registers 0 next edge; eqz=1; gcd_valid=0.
REQ-035 WIDTH=4, A=15, B=1 -> 14 iterations, gcd_out=1; A=15, B=0 -> B copy, gcd_out=15, iter_cnt=1.
